// File: rtl/issue_ctrl_if.sv
// Decoder-side enqueue port and downstream issue port of the issue controller.
interface issue_ctrl_if #(
    parameter int ROB_W = 4
);
    logic             rdy;
    logic             flush;
    logic             dec_valid;
    logic [5:0]       dec_opcode;
    logic [6:0]       dec_ophead;
    logic [31:0]      dec_imm;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [4:0]       dec_rd;
    logic             dec_ready;
    logic             rob_full;
    logic             rs_full;
    logic             lsb_full;
    logic [ROB_W-1:0] rob_tail;
    logic             rob_alloc;
    logic             rs_issue;
    logic             lsb_issue;
    logic [5:0]       iss_opcode;
    logic [31:0]      iss_imm;
    logic [4:0]       iss_rs1;
    logic [4:0]       iss_rs2;
    logic [4:0]       iss_rd;
    logic [ROB_W-1:0] iss_tag;
    logic             iss_wr;
    logic [15:0]      stall_cnt;

    modport master (
        output rdy, flush, dec_valid, dec_opcode, dec_ophead, dec_imm,
        output dec_rs1, dec_rs2, dec_rd, rob_full, rs_full, lsb_full, rob_tail,
        input  dec_ready, rob_alloc, rs_issue, lsb_issue, iss_opcode, iss_imm,
        input  iss_rs1, iss_rs2, iss_rd, iss_tag, iss_wr, stall_cnt
    );

    modport slave (
        input  rdy, flush, dec_valid, dec_opcode, dec_ophead, dec_imm,
        input  dec_rs1, dec_rs2, dec_rd, rob_full, rs_full, lsb_full, rob_tail,
        output dec_ready, rob_alloc, rs_issue, lsb_issue, iss_opcode, iss_imm,
        output iss_rs1, iss_rs2, iss_rd, iss_tag, iss_wr, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue queue between decoder and ROB/RS/LSB.
// Head entry is issued to RS or LSB with a ROB allocation in the same cycle.
module issue_ctrl #(
    parameter int ROB_W  = 4,
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    issue_ctrl_if.slave  io
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [5:0]  q_opcode [QDEPTH];
    logic [6:0]  q_ophead [QDEPTH];
    logic [31:0] q_imm    [QDEPTH];
    logic [4:0]  q_rs1    [QDEPTH];
    logic [4:0]  q_rs2    [QDEPTH];
    logic [4:0]  q_rd     [QDEPTH];

    logic [PW-1:0] hd;
    logic [PW-1:0] tl;
    logic [CW-1:0] count;
    logic [15:0]   stall_q;

    logic       not_empty;
    logic       live;
    logic [5:0] h_opcode;
    logic [6:0] h_ophead;
    logic       h_lsb;
    logic       h_illegal;
    logic       tgt_full;
    logic       issuable;
    logic       drop;
    logic       deq;
    logic       enq;
    logic       stall;

    assign not_empty = (count != '0) && !rst;
    assign live      = io.rdy && !io.flush && !rst;
    assign h_opcode  = not_empty ? q_opcode[hd] : 6'd0;
    assign h_ophead  = not_empty ? q_ophead[hd] : 7'd0;
    assign h_lsb     = (h_ophead == OP_LOAD) || (h_ophead == OP_STORE);
    assign h_illegal = (h_opcode == 6'd0);
    assign tgt_full  = h_lsb ? io.lsb_full : io.rs_full;

    assign issuable = not_empty && live && !h_illegal
                      && !io.rob_full && !tgt_full;
    // Illegal heads drain silently so they never wedge the queue.
    assign drop  = not_empty && live && h_illegal;
    assign deq   = issuable || drop;
    assign stall = not_empty && live && !h_illegal && !issuable;

    assign io.dec_ready = (count < FULL_CNT) && live;
    assign enq          = io.dec_valid && io.dec_ready;

    assign io.rob_alloc  = issuable;
    assign io.rs_issue   = issuable && !h_lsb;
    assign io.lsb_issue  = issuable && h_lsb;
    assign io.iss_opcode = h_opcode;
    assign io.iss_imm    = not_empty ? q_imm[hd] : 32'd0;
    assign io.iss_rs1    = not_empty ? q_rs1[hd] : 5'd0;
    assign io.iss_rs2    = not_empty ? q_rs2[hd] : 5'd0;
    assign io.iss_rd     = not_empty ? q_rd[hd]  : 5'd0;
    assign io.iss_tag    = issuable ? io.rob_tail : '0;
    assign io.iss_wr     = !((h_ophead == OP_BRANCH) || (h_ophead == OP_STORE)
                             || (io.iss_rd == 5'd0));
    assign io.stall_cnt  = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hd      <= '0;
            tl      <= '0;
            count   <= '0;
            stall_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_opcode[i] <= '0;
                q_ophead[i] <= '0;
                q_imm[i]    <= '0;
                q_rs1[i]    <= '0;
                q_rs2[i]    <= '0;
                q_rd[i]     <= '0;
            end
        end else if (io.flush) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else if (io.rdy) begin
            if (enq) begin
                q_opcode[tl] <= io.dec_opcode;
                q_ophead[tl] <= io.dec_ophead;
                q_imm[tl]    <= io.dec_imm;
                q_rs1[tl]    <= io.dec_rs1;
                q_rs2[tl]    <= io.dec_rs2;
                q_rd[tl]     <= io.dec_rd;
                tl           <= tl + 1'b1;
            end
            if (deq)
                hd <= hd + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
            if (stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: inputs change on the falling edge,
// outputs are checked 1ns later, well before the next rising edge.
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    issue_ctrl_if #(.ROB_W(4)) io ();

    issue_ctrl #(.ROB_W(4), .QDEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [5:0] opc,
                         input logic [6:0] oph, input logic [4:0] rd,
                         input logic [31:0] imm);
        io.dec_valid  = v;
        io.dec_opcode = opc;
        io.dec_ophead = oph;
        io.dec_rd     = rd;
        io.dec_imm    = imm;
        io.dec_rs1    = 5'd1;
        io.dec_rs2    = 5'd2;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 7'd0, 5'd0, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        io.rdy      = 1'b1;
        io.flush    = 1'b0;
        io.rob_full = 1'b0;
        io.rs_full  = 1'b0;
        io.lsb_full = 1'b0;
        io.rob_tail = 4'h3;
        idle();
        cyc();
        cyc();
        #1;
        chk("rst_dec_ready", io.dec_ready, 0);
        chk("rst_rob_alloc", io.rob_alloc, 0);
        chk("rst_iss_rd", io.iss_rd, 0);
        chk("rst_stall", io.stall_cnt, 0);

        // ADDI rd=5
        cyc();
        rst = 1'b0;
        drive(1'b1, 6'd1, 7'b0010011, 5'd5, 32'd100);
        #1;
        chk("addi_ready", io.dec_ready, 1);
        chk("addi_no_early", io.rob_alloc, 0);
        cyc();
        idle();
        #1;
        chk("addi_alloc", io.rob_alloc, 1);
        chk("addi_rs", io.rs_issue, 1);
        chk("addi_lsb", io.lsb_issue, 0);
        chk("addi_rd", io.iss_rd, 5);
        chk("addi_wr", io.iss_wr, 1);
        chk("addi_tag", io.iss_tag, 3);
        chk("addi_imm", io.iss_imm, 100);
        cyc();
        #1;
        chk("empty_alloc", io.rob_alloc, 0);
        chk("empty_rd", io.iss_rd, 0);

        // SW then BEQ with lsb_full for 3 blocked cycles
        cyc();
        io.lsb_full = 1'b1;
        drive(1'b1, 6'd2, 7'b0100011, 5'd0, 32'd8);
        cyc();
        drive(1'b1, 6'd3, 7'b1100011, 5'd0, 32'd12);
        #1;
        chk("sw_blocked", io.rob_alloc, 0);
        cyc();
        idle();
        #1;
        chk("sw_full_ready", io.dec_ready, 0);
        chk("sw_stall1", io.stall_cnt, 1);
        cyc();
        #1;
        chk("sw_stall2", io.stall_cnt, 2);
        chk("sw_lsb_blk", io.lsb_issue, 0);
        cyc();
        io.lsb_full = 1'b0;
        #1;
        chk("sw_stall3", io.stall_cnt, 3);
        chk("sw_lsb", io.lsb_issue, 1);
        chk("sw_rs", io.rs_issue, 0);
        chk("sw_alloc", io.rob_alloc, 1);
        chk("sw_wr", io.iss_wr, 0);
        cyc();
        #1;
        chk("beq_rs", io.rs_issue, 1);
        chk("beq_lsb", io.lsb_issue, 0);
        chk("beq_wr", io.iss_wr, 0);
        chk("beq_opc", io.iss_opcode, 3);
        cyc();
        #1;
        chk("beq_drained", io.rob_alloc, 0);
        chk("beq_stall_hold", io.stall_cnt, 3);

        // rob_full holding two entries
        cyc();
        io.rob_full = 1'b1;
        drive(1'b1, 6'd4, 7'b0110011, 5'd7, 32'd0);
        cyc();
        drive(1'b1, 6'd5, 7'b0110011, 5'd8, 32'd0);
        cyc();
        drive(1'b1, 6'd6, 7'b0110011, 5'd9, 32'd0);
        #1;
        chk("robf_ready", io.dec_ready, 0);
        chk("robf_alloc", io.rob_alloc, 0);
        chk("robf_rs", io.rs_issue, 0);
        cyc();
        idle();
        io.rob_full = 1'b0;
        #1;
        chk("robf_iss1", io.rob_alloc, 1);
        chk("robf_opc1", io.iss_opcode, 4);
        chk("robf_rd1", io.iss_rd, 7);
        cyc();
        #1;
        chk("robf_iss2", io.rob_alloc, 1);
        chk("robf_opc2", io.iss_opcode, 5);
        cyc();
        #1;
        chk("robf_no3", io.rob_alloc, 0);
        chk("robf_ready2", io.dec_ready, 1);
        chk("robf_stall", io.stall_cnt, 5);

        // full queue + flush + dec_valid
        cyc();
        io.rob_full = 1'b1;
        drive(1'b1, 6'd7, 7'b0110011, 5'd1, 32'd0);
        cyc();
        drive(1'b1, 6'd8, 7'b0110011, 5'd2, 32'd0);
        cyc();
        io.rob_full = 1'b0;
        io.flush = 1'b1;
        drive(1'b1, 6'd9, 7'b0110011, 5'd3, 32'd0);
        #1;
        chk("fl_alloc", io.rob_alloc, 0);
        chk("fl_rs", io.rs_issue, 0);
        chk("fl_ready", io.dec_ready, 0);
        cyc();
        io.flush = 1'b0;
        idle();
        #1;
        chk("fl_ready_after", io.dec_ready, 1);
        chk("fl_empty", io.rob_alloc, 0);
        chk("fl_absent", io.iss_opcode, 0);
        chk("fl_stall_kept", io.stall_cnt, 6);

        // illegal opcode 0
        drive(1'b1, 6'd0, 7'b0010011, 5'd3, 32'd0);
        cyc();
        idle();
        #1;
        chk("ill_alloc", io.rob_alloc, 0);
        chk("ill_rs", io.rs_issue, 0);
        chk("ill_lsb", io.lsb_issue, 0);
        cyc();
        #1;
        chk("ill_gone", io.iss_rd, 0);
        chk("ill_stall", io.stall_cnt, 6);

        // streaming 10 entries through a 2-deep queue
        for (int i = 0; i <= 10; i++) begin
            cyc();
            io.rob_tail = 4'(i);
            if (i < 10)
                drive(1'b1, 6'(10 + i), 7'b0010011, 5'(i + 1), 32'(i));
            else
                idle();
            #1;
            if (i > 0) begin
                chk("str_alloc", io.rob_alloc, 1);
                chk("str_opc", io.iss_opcode, 32'(10 + i - 1));
                chk("str_tag", io.iss_tag, 32'(i));
            end
            if (i < 10)
                chk("str_ready", io.dec_ready, 1);
        end
        cyc();
        #1;
        chk("str_drained", io.rob_alloc, 0);

        // rdy low freezes
        drive(1'b1, 6'd20, 7'b0010011, 5'd4, 32'd0);
        cyc();
        idle();
        io.rdy = 1'b0;
        #1;
        chk("rdy0_alloc", io.rob_alloc, 0);
        chk("rdy0_ready", io.dec_ready, 0);
        cyc();
        io.rdy = 1'b1;
        #1;
        chk("rdy1_alloc", io.rob_alloc, 1);
        chk("rdy1_opc", io.iss_opcode, 20);
        chk("rdy_stall", io.stall_cnt, 6);

        // reset mid-operation
        cyc();
        io.rob_full = 1'b1;
        drive(1'b1, 6'd21, 7'b0010011, 5'd4, 32'd0);
        cyc();
        drive(1'b1, 6'd22, 7'b0010011, 5'd5, 32'd0);
        cyc();
        idle();
        io.rob_full = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_alloc", io.rob_alloc, 0);
        chk("mrst_ready", io.dec_ready, 0);
        chk("mrst_opc", io.iss_opcode, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_empty", io.rob_alloc, 0);
        chk("mrst_stall", io.stall_cnt, 0);
        chk("mrst_ready2", io.dec_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter ROB_W, default 4, ROB tag width.
REQ-002 Parameter QDEPTH, default 2, issue queue depth; power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 rdy  input  1  global enable; low freezes all state.
REQ-006 dec_valid  input  1  decoded instruction present (decoder op_flag).
REQ-007 dec_opcode/dec_ophead/dec_imm  input  6/7/32  decoded opcode, ins[6:0], immediate.
REQ-008 dec_rs1/dec_rs2/dec_rd  input  5 each  register indices.
REQ-009 dec_ready  output  1  queue can accept an entry this cycle.
REQ-010 rob_full/rs_full/lsb_full  input  1 each  downstream full flags.
REQ-011 rob_tail  input  ROB_W  tag of next free ROB entry.
REQ-012 flush  input  1  mispredict/clear request.
REQ-013 rob_alloc/rs_issue/lsb_issue  output  1 each  single-cycle issue strobes.
REQ-014 iss_opcode/iss_imm/iss_rs1/iss_rs2/iss_rd  output  6/32/5/5/5  head entry fields.
REQ-015 iss_tag  output  ROB_W  equals rob_tail during an issue cycle.
REQ-016 iss_wr  output  1  instruction writes rd.
REQ-017 stall_cnt  output  16  saturating count of blocked-head cycles.

Function
REQ-018 Circular FIFO of QDEPTH entries; head/tail pointers wrap modulo QDEPTH; occupancy count 0..QDEPTH.
REQ-019 dec_ready = (count < QDEPTH) & !flush & rdy & !rst; combinational; no enqueue when full even if the head dequeues that cycle.
REQ-020 Enqueue at the clock edge when dec_valid & dec_ready; fields captured unchanged.
REQ-021 Head class: ophead 0000011 or 0100011 -> LSB; all other ophead -> RS.
REQ-022 Head issuable = count>0 & rdy & !flush & !rob_full & !(target full), where target is rs_full for RS class and lsb_full for LSB class.
REQ-023 On issuable: rob_alloc=1 plus exactly one of rs_issue/lsb_issue=1, same cycle (combinational from registered head); head dequeues at the edge.
REQ-024 Head with opcode 0 (illegal): dequeued in one cycle with all strobes 0; not counted as a stall.
REQ-025 iss_wr = 0 for ophead 1100011 or 0100011, or when iss_rd = 0; otherwise 1.
REQ-026 Latency: an entry enqueued at edge N, into an empty queue, issues at the earliest in cycle N+1.
REQ-027 Strobes are 0 whenever not issuing; iss_* fields show the head, or 0 when empty.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-029 flush: strobes 0 that cycle; at the edge count and both pointers become 0 and any enqueue is discarded; flush overrides rdy.
REQ-030 stall_cnt increments when count>0, the head opcode is nonzero, rdy=1, flush=0, and the head is not issuable; it saturates at 0xFFFF and is not cleared by flush.
REQ-031 rdy=0 (without flush): pointers, count, and stall_cnt hold; strobes 0.

Reset
REQ-032 rst at the edge: count, pointers, and stall_cnt are set to 0 and entries cleared; during rst all strobes, iss_* and dec_ready are 0.
REQ-033 rst asserted mid-operation discards queued entries; no strobe occurs in the cycle rst is high.
REQ-034 rst has priority over flush and rdy.

Verification
REQ-035 After reset, enqueue ADDI (ophead 0010011, rd=5), with all full flags 0 -> next cycle rob_alloc=1, rs_issue=1, lsb_issue=0, iss_rd=5, iss_wr=1, iss_tag=rob_tail.
REQ-036 Enqueue SW, then BEQ, with lsb_full=1 for 3 cycles -> SW blocks for 3 cycles with stall_cnt=3, dec_ready=0 while full; SW issues with lsb_issue=1 and iss_wr=0, then BEQ follows with rs_issue=1 and iss_wr=0.
REQ-037 rob_full=1 with 2 entries queued, enqueue attempted -> dec_ready=0, no strobes, count stays 2; releasing rob_full -> back-to-back issues in 2 cycles.
REQ-038 Queue full plus flush=1 together with dec_valid=1 -> no strobes that cycle; next cycle count=0, dec_ready=1, and the flushed-cycle instruction is absent.
REQ-039 Enqueue with opcode 0 -> dequeued with no strobes, and stall_cnt unchanged.
REQ-040 Continuous enqueue/issue for 10 entries with QDEPTH=2 -> pointer wrap-around; order preserved, one issue per cycle, no loss or duplication.
